// File: rtl/bram_arbiter_if.sv
// Request/response and memory-port bundle for bram_arbiter.
// Handshake: a request is accepted on any rising edge where req_valid[i] and req_ready[i] are both high.
interface bram_arbiter_if;
    logic [2:0]  req_valid;
    logic [2:0]  req_we;
    logic [47:0] req_addr;
    logic [47:0] req_wdata;
    logic [2:0]  req_ready;
    logic [2:0]  rsp_valid;
    logic [15:0] rsp_data;
    logic        lock_req;
    logic        lock_ack;
    logic        mem_wren_n;
    logic        mem_oen_n;
    logic [15:0] mem_wraddress;
    logic [15:0] mem_rdaddress;
    logic [15:0] mem_data_in;
    logic [15:0] mem_data_out;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, lock_req, mem_data_out,
        output req_ready, rsp_valid, rsp_data, lock_ack,
               mem_wren_n, mem_oen_n, mem_wraddress, mem_rdaddress, mem_data_in
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, lock_req, mem_data_out,
        input  req_ready, rsp_valid, rsp_data, lock_ack,
               mem_wren_n, mem_oen_n, mem_wraddress, mem_rdaddress, mem_data_in
    );
endinterface

// File: rtl/bram_arbiter.sv
// Three-requester arbiter for a 1R/1W block RAM: independent round-robin read and write
// arbiters plus a host lock FSM (RUN -> DRAIN -> LOCKED) for exclusive host access.
module bram_arbiter #(
    parameter int BITS = 12
) (
    input  logic           clk,
    input  logic           rst_n,
    bram_arbiter_if.slave  bus,
    output logic [1:0]     o_dbg_state
);
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    localparam logic [15:0] ADDR_MASK = 16'((32'd1 << BITS) - 32'd1);

    state_e      r_state;
    state_e      w_next_state;
    logic [1:0]  r_rd_ptr;
    logic [1:0]  r_wr_ptr;
    logic [2:0]  r_rsp_valid;
    logic        r_lock_ack;
    logic        w_lock_ack_nxt;
    logic [2:0]  w_allow;
    logic [2:0]  w_we;
    logic [2:0]  w_rd_elig;
    logic [2:0]  w_wr_elig;
    logic [2:0]  w_rd_gnt;
    logic [2:0]  w_wr_gnt;

    // Pointer names the highest-priority requester; search continues upward mod 3.
    function automatic logic [2:0] rr_pick(input logic [2:0] e, input logic [1:0] p);
        logic [2:0] g;
        g = 3'b000;
        case (p)
            2'd1:    g = e[1] ? 3'b010 : e[2] ? 3'b100 : e[0] ? 3'b001 : 3'b000;
            2'd2:    g = e[2] ? 3'b100 : e[0] ? 3'b001 : e[1] ? 3'b010 : 3'b000;
            default: g = e[0] ? 3'b001 : e[1] ? 3'b010 : e[2] ? 3'b100 : 3'b000;
        endcase
        return g;
    endfunction

    function automatic logic [1:0] ptr_next(input logic [2:0] g, input logic [1:0] p);
        logic [1:0] n;
        case (g)
            3'b001:  n = 2'd1;
            3'b010:  n = 2'd2;
            3'b100:  n = 2'd0;
            default: n = p;
        endcase
        return n;
    endfunction

    function automatic logic [15:0] sel16(input logic [2:0] g, input logic [47:0] v);
        logic [15:0] r;
        r = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            if (g[i]) r = v[16*i +: 16];
        end
        return r;
    endfunction

    // Lock FSM: state register (lock_ack tracks the LOCKED state edge-for-edge).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_lock_ack <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_lock_ack <= w_lock_ack_nxt;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_RUN:    if (bus.lock_req) w_next_state = ST_DRAIN;
            ST_DRAIN: begin
                if (!bus.lock_req)               w_next_state = ST_RUN;
                else if (r_rsp_valid[1:0] == 2'b00) w_next_state = ST_LOCKED;
            end
            ST_LOCKED: if (!bus.lock_req) w_next_state = ST_RUN;
            default:   w_next_state = ST_RUN;
        endcase
    end

    // Grants are suppressed while reset is held so the memory enables stay inactive.
    always_comb begin
        w_allow        = 3'b000;
        w_lock_ack_nxt = (w_next_state == ST_LOCKED);
        if (rst_n) w_allow = (r_state == ST_RUN) ? 3'b111 : 3'b100;
    end

    assign w_we      = {bus.req_we[2:1], 1'b0};
    assign w_rd_elig = bus.req_valid & ~w_we & w_allow;
    assign w_wr_elig = bus.req_valid &  w_we & w_allow;
    assign w_rd_gnt  = rr_pick(w_rd_elig, r_rd_ptr);
    assign w_wr_gnt  = rr_pick(w_wr_elig, r_wr_ptr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr    <= 2'd0;
            r_wr_ptr    <= 2'd0;
            r_rsp_valid <= 3'b000;
        end else begin
            r_rd_ptr    <= ptr_next(w_rd_gnt, r_rd_ptr);
            r_wr_ptr    <= ptr_next(w_wr_gnt, r_wr_ptr);
            r_rsp_valid <= w_rd_gnt;
        end
    end

    assign bus.req_ready     = w_rd_gnt | w_wr_gnt;
    assign bus.rsp_valid     = r_rsp_valid;
    assign bus.rsp_data      = bus.mem_data_out;
    assign bus.lock_ack      = r_lock_ack;
    assign bus.mem_oen_n     = ~|w_rd_gnt;
    assign bus.mem_wren_n    = ~|w_wr_gnt;
    assign bus.mem_rdaddress = sel16(w_rd_gnt, bus.req_addr) & ADDR_MASK;
    assign bus.mem_wraddress = sel16(w_wr_gnt, bus.req_addr) & ADDR_MASK;
    assign bus.mem_data_in   = sel16(w_wr_gnt, bus.req_wdata);
    assign o_dbg_state       = r_state;
endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter with a registered-read 4K x 16 memory model.
module tb_bram_arbiter;
    logic        clk;
    logic        rst_n;
    logic [1:0]  dbg_state;
    int          err_cnt;
    int          chk_cnt;
    int          pulse_cnt[3];
    logic [2:0]  rr_exp[6];
    logic [15:0] mem[0:4095];

    bram_arbiter_if bus();

    bram_arbiter #(.BITS(12)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!bus.mem_wren_n) mem[bus.mem_wraddress[11:0]] <= bus.mem_data_in;
        if (!bus.mem_oen_n)  bus.mem_data_out <= mem[bus.mem_rdaddress[11:0]];
    end

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.req_valid = 3'b000;
        bus.req_we    = 3'b000;
        bus.req_addr  = 48'h0;
        bus.req_wdata = 48'h0;
    endtask

    task automatic set_req(input int i, input logic we, input logic [15:0] a, input logic [15:0] d);
        bus.req_valid[i]         = 1'b1;
        bus.req_we[i]            = we;
        bus.req_addr[16*i +: 16]  = a;
        bus.req_wdata[16*i +: 16] = d;
    endtask

    task automatic next_cyc();
        @(negedge clk);
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        err_cnt = 0;
        chk_cnt = 0;
        rst_n = 1'b0;
        bus.lock_req = 1'b0;
        idle();
        rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_rsp_valid", 16'(bus.rsp_valid), 16'h0);
        check_eq("rst_lock_ack", 16'(bus.lock_ack), 16'h0);
        check_eq("rst_oen_n", 16'(bus.mem_oen_n), 16'h1);
        check_eq("rst_wren_n", 16'(bus.mem_wren_n), 16'h1);
        check_eq("rst_state", 16'(dbg_state), 16'h0);
        rst_n = 1'b1;

        // Preload through the host write port.
        next_cyc(); set_req(2, 1'b1, 16'h0010, 16'h1234); #1;
        check_eq("pre_ready", 16'(bus.req_ready), 16'h4);
        check_eq("pre_wren_n", 16'(bus.mem_wren_n), 16'h0);
        check_eq("pre_wraddr", bus.mem_wraddress, 16'h0010);
        check_eq("pre_wdata", bus.mem_data_in, 16'h1234);
        next_cyc(); set_req(2, 1'b1, 16'h0005, 16'h1111); #1;
        check_eq("pre2_ready", 16'(bus.req_ready), 16'h4);

        // Single fetch read.
        next_cyc(); set_req(0, 1'b0, 16'h0010, 16'h0); #1;
        check_eq("rd_ready", 16'(bus.req_ready), 16'h1);
        check_eq("rd_oen_n", 16'(bus.mem_oen_n), 16'h0);
        check_eq("rd_addr", bus.mem_rdaddress, 16'h0010);
        next_cyc(); #1;
        check_eq("rd_rsp_valid", 16'(bus.rsp_valid), 16'h1);
        check_eq("rd_rsp_data", bus.rsp_data, 16'h1234);
        check_eq("rd_idle_oen_n", 16'(bus.mem_oen_n), 16'h1);
        check_eq("rd_idle_addr", bus.mem_rdaddress, 16'h0000);

        // Host read with upper address bits set; also returns the read pointer to 0.
        next_cyc(); set_req(2, 1'b0, 16'hF123, 16'h0); #1;
        check_eq("mask_ready", 16'(bus.req_ready), 16'h4);
        check_eq("mask_addr", bus.mem_rdaddress, 16'h0123);
        next_cyc(); #1;
        check_eq("mask_rsp_valid", 16'(bus.rsp_valid), 16'h4);

        // Read round-robin with all three requesters pending.
        pulse_cnt = '{0, 0, 0};
        for (int k = 0; k < 6; k++) begin
            next_cyc();
            set_req(0, 1'b0, 16'h0001, 16'h0);
            set_req(1, 1'b0, 16'h0002, 16'h0);
            set_req(2, 1'b0, 16'h0003, 16'h0);
            #1;
            check_eq("rr_ready", 16'(bus.req_ready), 16'(rr_exp[k]));
            if (k > 0) check_eq("rr_rsp", 16'(bus.rsp_valid), 16'(rr_exp[k-1]));
            for (int j = 0; j < 3; j++) pulse_cnt[j] += int'(bus.rsp_valid[j]);
        end
        next_cyc(); #1;
        check_eq("rr_rsp_last", 16'(bus.rsp_valid), 16'h4);
        for (int j = 0; j < 3; j++) pulse_cnt[j] += int'(bus.rsp_valid[j]);
        for (int j = 0; j < 3; j++) check_eq("rr_pulses", 16'(pulse_cnt[j]), 16'h2);

        // Same-address read and write in one cycle.
        next_cyc();
        set_req(1, 1'b1, 16'h0005, 16'hBEEF);
        set_req(0, 1'b0, 16'h0005, 16'h0);
        #1;
        check_eq("rw_ready", 16'(bus.req_ready), 16'h3);
        next_cyc(); set_req(0, 1'b0, 16'h0005, 16'h0); #1;
        check_eq("rw_old_valid", 16'(bus.rsp_valid), 16'h1);
        check_eq("rw_old_data", bus.rsp_data, 16'h1111);
        next_cyc(); #1;
        check_eq("rw_new_data", bus.rsp_data, 16'hBEEF);

        // Write round-robin: write pointer sits at 2 after the data write.
        next_cyc();
        set_req(1, 1'b1, 16'h0100, 16'h0A0A);
        set_req(2, 1'b1, 16'h0101, 16'h0B0B);
        #1;
        check_eq("wrr_ready0", 16'(bus.req_ready), 16'h4);
        next_cyc();
        set_req(1, 1'b1, 16'h0100, 16'h0A0A);
        set_req(2, 1'b1, 16'h0101, 16'h0B0B);
        #1;
        check_eq("wrr_ready1", 16'(bus.req_ready), 16'h2);
        check_eq("wrr_wdata1", bus.mem_data_in, 16'h0A0A);

        // Lock while fetch streams reads.
        next_cyc(); set_req(0, 1'b0, 16'h0010, 16'h0); #1;
        check_eq("lk0_ready", 16'(bus.req_ready), 16'h1);
        next_cyc(); set_req(0, 1'b0, 16'h0010, 16'h0); bus.lock_req = 1'b1; #1;
        check_eq("lk1_ready", 16'(bus.req_ready), 16'h1);
        next_cyc(); set_req(0, 1'b0, 16'h0010, 16'h0); #1;
        check_eq("lk2_ready", 16'(bus.req_ready), 16'h0);
        check_eq("lk2_state", 16'(dbg_state), 16'h1);
        check_eq("lk2_ack", 16'(bus.lock_ack), 16'h0);
        next_cyc(); set_req(0, 1'b0, 16'h0010, 16'h0); #1;
        check_eq("lk3_ack", 16'(bus.lock_ack), 16'h0);
        check_eq("lk3_ready", 16'(bus.req_ready), 16'h0);
        next_cyc(); set_req(0, 1'b0, 16'h0010, 16'h0); set_req(2, 1'b1, 16'h0FFF, 16'h00AA); #1;
        check_eq("lk4_ack", 16'(bus.lock_ack), 16'h1);
        check_eq("lk4_ready", 16'(bus.req_ready), 16'h4);
        next_cyc(); set_req(0, 1'b0, 16'h0010, 16'h0); set_req(2, 1'b0, 16'h0FFF, 16'h0); #1;
        check_eq("lk5_ready", 16'(bus.req_ready), 16'h4);
        next_cyc(); set_req(0, 1'b0, 16'h0010, 16'h0); bus.lock_req = 1'b0; #1;
        check_eq("lk6_rsp_valid", 16'(bus.rsp_valid), 16'h4);
        check_eq("lk6_rsp_data", bus.rsp_data, 16'h00AA);
        check_eq("lk6_ready", 16'(bus.req_ready), 16'h0);
        next_cyc(); set_req(0, 1'b0, 16'h0010, 16'h0); #1;
        check_eq("lk7_ack", 16'(bus.lock_ack), 16'h0);
        check_eq("lk7_ready", 16'(bus.req_ready), 16'h1);

        // Lock with no outstanding fetch/data read: ack one edge sooner.
        next_cyc();
        next_cyc(); bus.lock_req = 1'b1;
        next_cyc(); #1;
        check_eq("lkf_state", 16'(dbg_state), 16'h1);
        check_eq("lkf_ack0", 16'(bus.lock_ack), 16'h0);
        next_cyc(); #1;
        check_eq("lkf_ack1", 16'(bus.lock_ack), 16'h1);
        bus.lock_req = 1'b0;
        next_cyc(); #1;
        check_eq("lkf_ack_drop", 16'(bus.lock_ack), 16'h0);
        check_eq("lkf_state_run", 16'(dbg_state), 16'h0);

        // Asynchronous reset with a read response pending.
        next_cyc(); set_req(0, 1'b0, 16'h0010, 16'h0); set_req(1, 1'b0, 16'h0010, 16'h0); #1;
        check_eq("ar_ready", 16'(bus.req_ready), 16'h2);
        next_cyc(); #1;
        check_eq("ar_rsp_before", 16'(bus.rsp_valid), 16'h2);
        rst_n = 1'b0; #1;
        check_eq("ar_rsp_during", 16'(bus.rsp_valid), 16'h0);
        check_eq("ar_ack_during", 16'(bus.lock_ack), 16'h0);
        @(negedge clk);
        rst_n = 1'b1; #1;
        check_eq("ar_rsp_after", 16'(bus.rsp_valid), 16'h0);
        next_cyc();
        set_req(0, 1'b0, 16'h0001, 16'h0);
        set_req(1, 1'b0, 16'h0002, 16'h0);
        set_req(2, 1'b0, 16'h0003, 16'h0);
        #1;
        check_eq("ar_first_ready", 16'(bus.req_ready), 16'h1);
        next_cyc(); #1;
        check_eq("ar_first_rsp", 16'(bus.rsp_valid), 16'h1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
